// File: rtl/muldiv_ctrl_if.sv
// ----------------------------------------------------------------------------
// muldiv_ctrl_if
//   Bundle between the execute stage, the multiply/divide sequencer and the
//   HiLo register pair.
//
//   master (EXU side) drives : start, op, opa, opb, cancel
//   slave  (sequencer) drives: busy, done, dz, wHiData, whi, wLoData, wlo
//
//   start   request strobe, sampled only while the sequencer is idle/done
//   op      0=MULTU 1=MULT 2=DIVU 3=DIV
//   opa     rs operand (multiplicand / dividend)
//   opb     rt operand (multiplier / divisor)
//   cancel  flush: abort, no HiLo write
//   busy    stall request to IFU/IDU
//   done    one-cycle completion pulse
//   dz      divide-by-zero flag, valid with done
//   wHiData/whi, wLoData/wlo  HiLo write port
// ----------------------------------------------------------------------------
interface muldiv_ctrl_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        cancel;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] wHiData;
    logic        whi;
    logic [31:0] wLoData;
    logic        wlo;

    modport master (
        output start, op, opa, opb, cancel,
        input  busy, done, dz, wHiData, whi, wLoData, wlo
    );

    modport slave (
        input  start, op, opa, opb, cancel,
        output busy, done, dz, wHiData, whi, wLoData, wlo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// muldiv_ctrl
//   Multi-cycle multiply/divide sequencer owning the HiLo write port.
//   Runs a 32-step shift-add multiply or restoring divide on operand
//   magnitudes, applies a sign fix-up, then pulses a single HiLo write.
//
//   Ports:
//     clk   CPU clock, all state changes on the rising edge
//     rst   synchronous, active-high reset
//     bus   muldiv_ctrl_if.slave (request in, stall/result out)
//
//   Parameter:
//     ITER  iteration count, must equal the operand width (32)
// ----------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int unsigned ITER = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [63:0] acc_q;     // {Hi,Lo}: product/multiplier or remainder/quotient
    logic [31:0] oper_q;    // multiplicand magnitude or divisor magnitude
    logic        is_div_q;
    logic        neg_q;     // negate product (mult) or quotient (div)
    logic        rneg_q;    // negate remainder (div only)
    logic [5:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        dz_q;
    logic        wr_q;

    // Request decode
    logic        accept;
    logic        req_signed;
    logic        req_div;
    logic        req_dz;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    // Datapath next values
    logic [32:0] mul_sum;
    logic [63:0] mul_d;
    logic [32:0] div_top;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] div_d;
    logic [63:0] fix_d;

    always_comb begin
        accept     = bus.start && !bus.cancel;
        req_signed = bus.op[0];
        req_div    = bus.op[1];
        req_dz     = req_div && (bus.opb == '0);
        a_mag      = (req_signed && bus.opa[31]) ? (~bus.opa + 32'd1) : bus.opa;
        b_mag      = (req_signed && bus.opb[31]) ? (~bus.opb + 32'd1) : bus.opb;
    end

    always_comb begin
        // Shift-add: add multiplicand into the upper half when the multiplier
        // LSB (acc[0]) is set, then shift the 65-bit result right by one.
        mul_sum = {1'b0, acc_q[63:32]} + {1'b0, oper_q};
        mul_d   = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};

        // Restoring divide: the shifted remainder can be 33 bits wide, so the
        // trial compare uses the bit shifted out of Hi. When it succeeds the
        // difference is below the divisor and fits in 32 bits.
        div_top = {acc_q[63:32], acc_q[31]};
        div_ge  = (div_top >= {1'b0, oper_q});
        div_rem = div_top[31:0] - oper_q;
        div_d   = div_ge ? {div_rem, acc_q[30:0], 1'b1}
                         : {div_top[31:0], acc_q[30:0], 1'b0};

        if (is_div_q) begin
            fix_d = {rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32],
                     neg_q  ? (~acc_q[31:0]  + 32'd1) : acc_q[31:0]};
        end else begin
            fix_d = neg_q ? (~acc_q + 64'd1) : acc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            oper_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            wr_q   <= 1'b0;
            if (bus.cancel) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        busy_q <= 1'b0;
                        if (accept) begin
                            is_div_q <= req_div;
                            neg_q    <= req_signed && (bus.opa[31] ^ bus.opb[31]);
                            rneg_q   <= req_signed && bus.opa[31];
                            cnt_q    <= '0;
                            if (req_dz) begin
                                state_q <= S_DONE;
                                acc_q   <= {bus.opa, 32'hFFFF_FFFF};
                                done_q  <= 1'b1;
                                dz_q    <= 1'b1;
                                wr_q    <= 1'b1;
                            end else begin
                                state_q <= S_ITER;
                                busy_q  <= 1'b1;
                                acc_q   <= {32'd0, req_div ? a_mag : b_mag};
                                oper_q  <= req_div ? b_mag : a_mag;
                            end
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_ITER: begin
                        busy_q <= 1'b1;
                        acc_q  <= is_div_q ? div_d : mul_d;
                        cnt_q  <= cnt_q + 6'd1;
                        if (cnt_q == 6'(ITER - 1)) begin
                            state_q <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        acc_q   <= fix_d;
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        wr_q    <= 1'b1;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.dz      = dz_q;
    assign bus.whi     = wr_q;
    assign bus.wlo     = wr_q;
    assign bus.wHiData = acc_q[63:32];
    assign bus.wLoData = acc_q[31:0];

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

    logic clk;
    logic rst;

    muldiv_ctrl_if bus ();

    muldiv_ctrl #(.ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    // Architectural result of a request, straight from the instruction rules.
    function automatic res_t ref_model(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        res_t   r;
        longint sa, sb, q, rm;
        logic [63:0] p;
        r.dz = 1'b0;
        r.hi = '0;
        r.lo = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin
                p = {32'd0, a} * {32'd0, b};
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            2'd1: begin
                p = 64'(sa * sb);
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            2'd2: begin
                if (b == 0) begin
                    r.dz = 1'b1; r.hi = a; r.lo = 32'hFFFF_FFFF;
                end else begin
                    r.hi = a % b;
                    r.lo = a / b;
                end
            end
            default: begin
                if (b == 0) begin
                    r.dz = 1'b1; r.hi = a; r.lo = 32'hFFFF_FFFF;
                end else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r.hi = rm[31:0];
                    r.lo = q[31:0];
                end
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference timeline ----------------
    // A request that is not a divide-by-zero completes 33 edges after the
    // edge that accepts it; busy covers every cycle in between.
    bit   m_valid = 0;
    bit   m_busy  = 0;
    bit   m_done  = 0;
    int   m_left  = 0;
    res_t m_pend;
    res_t m_res;

    always @(posedge clk) begin
        res_t r;
        m_done = 0;
        if (rst || bus.cancel) begin
            m_left = 0;
            m_busy = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_done = 1;
                m_res  = m_pend;
            end
        end else if (bus.start) begin
            r = ref_model(bus.op, bus.opa, bus.opb);
            if (r.dz) begin
                m_done = 1;
                m_busy = 0;
                m_res  = r;
            end else begin
                m_left = 33;
                m_busy = 1;
                m_pend = r;
            end
        end
        m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("whi",  32'(bus.whi),  32'(m_done));
            chk("wlo",  32'(bus.wlo),  32'(m_done));
            if (m_done) begin
                chk("dz", 32'(bus.dz), 32'(m_res.dz));
                chk("hi", bus.wHiData, m_res.hi);
                chk("lo", bus.wLoData, m_res.lo);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_now(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Called just after the accepting edge; lat = further edges until done.
    task automatic wait_done(output int lat, output bit got);
        got = 0;
        lat = -1;
        for (int i = 0; i < 50; i++) begin
            if (bus.done === 1'b1) begin
                got = 1;
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL timeout: no done within 50 cycles at %0t", $time);
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit b2b, output logic [31:0] hi, output logic [31:0] lo,
                         output logic dz, output int lat);
        bit got;
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        start_now(op, a, b);
        wait_done(lat, got);
        hi = bus.wHiData;
        lo = bus.wLoData;
        dz = bus.dz;
    endtask

    task automatic directed(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] ehi,
                            input logic [31:0] elo, input logic edz, input int elat);
        logic [31:0] hi, lo;
        logic        dz;
        int          lat;
        do_op(op, a, b, 1'b0, hi, lo, dz, lat);
        chk({name, ".hi"}, hi, ehi);
        chk({name, ".lo"}, lo, elo);
        chk({name, ".dz"}, 32'(dz), 32'(edz));
        chk({name, ".lat"}, 32'(lat), 32'(elat));
    endtask

    task automatic abort_test(input bit use_rst);
        @(posedge clk);
        #1;
        start_now(2'd1, 32'hFFFF_FFFD, 32'd5);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        chk("abort.busy_before", 32'(bus.busy), 32'd1);
        if (use_rst) rst = 1'b1;
        else         bus.cancel = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.cancel = 1'b0;
        chk("abort.busy_after", 32'(bus.busy), 32'd0);
        chk("abort.done_after", 32'(bus.done), 32'd0);
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        chk("abort.busy_late", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global timeout at %0t", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        logic [31:0] hi, lo, a, b;
        logic        dz;
        logic [1:0]  op;
        int          lat;
        res_t        r;

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = '0;
        bus.opa    = '0;
        bus.opb    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.done", 32'(bus.done), 32'd0);
        chk("reset.dz",   32'(bus.dz),   32'd0);
        chk("reset.whi",  32'(bus.whi),  32'd0);
        chk("reset.wlo",  32'(bus.wlo),  32'd0);
        chk("reset.hi",   bus.wHiData,   32'd0);
        chk("reset.lo",   bus.wLoData,   32'd0);
        rst = 1'b0;

        directed("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
        directed("mult_m3x5", 2'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33);
        directed("mult_min",  2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0, 33);
        directed("div_m7d2",  2'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
        directed("div_7dm2",  2'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 33);
        directed("divu_100d7",2'd2, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33);
        directed("div_ovf",   2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0, 33);
        directed("divu_5d0",  2'd2, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 0);
        directed("div_m9d0",  2'd3, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1, 0);

        abort_test(1'b0);
        abort_test(1'b1);

        // start and cancel together: nothing may begin
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        bus.op     = 2'd0;
        bus.opa    = 32'd3;
        bus.opb    = 32'd4;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        chk("startcancel.busy", 32'(bus.busy), 32'd0);
        chk("startcancel.done", 32'(bus.done), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // back-to-back: new request held during the DONE cycle
        do_op(2'd0, 32'd1000, 32'd3000, 1'b0, hi, lo, dz, lat);
        chk("b2b.first.lo", lo, 32'd3000000);
        do_op(2'd3, 32'hFFFF_FF9C, 32'd7, 1'b1, hi, lo, dz, lat);
        chk("b2b.second.lo",  lo, 32'hFFFF_FFF2);
        chk("b2b.second.hi",  hi, 32'hFFFF_FFFE);
        chk("b2b.second.lat", 32'(lat), 32'd33);

        // randomized requests, some issued back-to-back
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 20);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            do_op(op, a, b, (i > 0) && ($urandom_range(0, 3) == 0), hi, lo, dz, lat);
            r = ref_model(op, a, b);
            chk("rand.hi",  hi, r.hi);
            chk("rand.lo",  lo, r.lo);
            chk("rand.dz",  32'(dz), 32'(r.dz));
            chk("rand.lat", 32'(lat), r.dz ? 32'd0 : 32'd33);
        end

        repeat (5) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
